pipeline_sequencer: RTL and testbench

//  Stage-enable/flush controller for the 5-stage pipeline register bank (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipeline_sequencer_pkg.sv | 28 ++
 rtl/pipeline_sequencer_if.sv | 39 +++
 rtl/pipeline_sequencer_load_use_detect.sv | 15 +
 rtl/pipeline_sequencer.sv | 97 +++++++++
 tb/tb_pipeline_sequencer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_sequencer_pkg.sv
// rtl/pipeline_sequencer_pkg.sv - shared types and stage-control patterns for the pipeline sequencer
package pipeline_sequencer_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } pctrl_state_t;

  // One cycle's worth of stage controls; en[N]/flush[N] act on pipeline register N
  typedef struct packed {
    logic       pc_en;
    logic [4:1] en;
    logic [3:1] flush;
  } stage_ctrl_t;

  // Bit layout: {pc_en, en_4, en_3, en_2, en_1, flush_3, flush_2, flush_1}
  localparam stage_ctrl_t CTRL_RESET     = 8'b0_0000_111;
  localparam stage_ctrl_t CTRL_FROZEN    = 8'b0_0000_000;
  localparam stage_ctrl_t CTRL_WB_ONLY   = 8'b0_1000_000;
  localparam stage_ctrl_t CTRL_REDIRECT  = 8'b1_1111_111;
  localparam stage_ctrl_t CTRL_LOAD_USE  = 8'b0_1110_010;
  localparam stage_ctrl_t CTRL_IF_BUBBLE = 8'b0_1111_001;
  localparam stage_ctrl_t CTRL_ADVANCE   = 8'b1_1111_000;

endpackage

// File: rtl/pipeline_sequencer_if.sv
// rtl/pipeline_sequencer_if.sv - hazard inputs and stage-control outputs of the pipeline sequencer
interface pipeline_sequencer_if #(
  parameter int CNT_W = 16
) ();
  import pipeline_sequencer_pkg::*;

  logic             ihit;
  logic             dhit;
  regbits_t         rs_id;
  regbits_t         rt_id;
  logic             dREN_ex;
  regbits_t         rt_ex;
  logic             dREN_mem;
  logic             dWEN_mem;
  logic             take_mem;
  logic             halt_wb;

  logic             pc_en;
  logic             en_1;
  logic             en_2;
  logic             en_3;
  logic             en_4;
  logic             flush_1;
  logic             flush_2;
  logic             flush_3;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output ihit, dhit, rs_id, rt_id, dREN_ex, rt_ex, dREN_mem, dWEN_mem, take_mem, halt_wb,
    input  pc_en, en_1, en_2, en_3, en_4, flush_1, flush_2, flush_3, halted, stall_cnt
  );

  modport slave (
    input  ihit, dhit, rs_id, rt_id, dREN_ex, rt_ex, dREN_mem, dWEN_mem, take_mem, halt_wb,
    output pc_en, en_1, en_2, en_3, en_4, flush_1, flush_2, flush_3, halted, stall_cnt
  );

endinterface

// File: rtl/pipeline_sequencer_load_use_detect.sv
// rtl/pipeline_sequencer_load_use_detect.sv - flags an IF/ID instruction reading the load in ID/EX
module pipeline_sequencer_load_use_detect
  import pipeline_sequencer_pkg::*;
(
  input  regbits_t rs_id,
  input  regbits_t rt_id,
  input  logic     dren_ex,
  input  regbits_t rt_ex,
  output logic     lu_stall
);

  // $zero never carries a real dependency, so a load targeting it never stalls
  assign lu_stall = dren_ex && (rt_ex != '0) && ((rt_ex == rs_id) || (rt_ex == rt_id));

endmodule

// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - stage enable/flush controller for the 5-stage pipeline register bank
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 CLK,
  input  logic                 nRST,
  pipeline_sequencer_if.slave  bus
);

  pctrl_state_t     state_q;
  pctrl_state_t     state_d;
  stage_ctrl_t      run_ctrl;
  stage_ctrl_t      ctrl;
  logic             lu_stall;
  logic             mem_pend;
  logic [CNT_W-1:0] cnt_q;

  pipeline_sequencer_load_use_detect u_lu (
    .rs_id    (bus.rs_id),
    .rt_id    (bus.rt_id),
    .dren_ex  (bus.dREN_ex),
    .rt_ex    (bus.rt_ex),
    .lu_stall (lu_stall)
  );

  // A data access in EX/MEM that has not completed holds the whole pipe
  assign mem_pend = (bus.dREN_mem || bus.dWEN_mem) && !bus.dhit;

  // State register; reset always lands in RUN with nothing pending
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Next state: halt commits first, then a missing data access parks us in DWAIT
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (bus.halt_wb)  state_d = HALTED;
        else if (mem_pend) state_d = DWAIT;
      end
      DWAIT:   if (bus.dhit) state_d = RUN;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  // Normal-flow controls: redirect beats load-use (its victim is flushed anyway), load-use beats I-miss
  always_comb begin
    run_ctrl = CTRL_ADVANCE;
    if (bus.take_mem)   run_ctrl = CTRL_REDIRECT;
    else if (lu_stall)  run_ctrl = CTRL_LOAD_USE;
    else if (!bus.ihit) run_ctrl = CTRL_IF_BUBBLE;
  end

  // Output decode from state and inputs; reset forces bubbles into IF/ID..EX/MEM
  always_comb begin
    ctrl = CTRL_FROZEN;
    if (!nRST) begin
      ctrl = CTRL_RESET;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.halt_wb)   ctrl = CTRL_WB_ONLY;
          else if (mem_pend) ctrl = CTRL_FROZEN;
          else               ctrl = run_ctrl;
        end
        DWAIT:   ctrl = bus.dhit ? run_ctrl : CTRL_FROZEN;
        default: ctrl = CTRL_FROZEN;
      endcase
    end
  end

  // Saturating count of cycles the PC was held while the core was still live
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else if (!ctrl.pc_en && (state_q != HALTED) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.pc_en     = ctrl.pc_en;
  assign bus.en_1      = ctrl.en[1];
  assign bus.en_2      = ctrl.en[2];
  assign bus.en_3      = ctrl.en[3];
  assign bus.en_4      = ctrl.en[4];
  assign bus.flush_1   = ctrl.flush[1];
  assign bus.flush_2   = ctrl.flush[2];
  assign bus.flush_3   = ctrl.flush[3];
  assign bus.halted    = (state_q == HALTED);
  assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb/tb_pipeline_sequencer.sv - vector table, corner sequences and randomized model check of pipeline_sequencer
module tb_pipeline_sequencer;
  import pipeline_sequencer_pkg::*;

  logic     CLK = 1'b0;
  logic     nRST;
  logic     ihit, dhit, dREN_ex, dREN_mem, dWEN_mem, take_mem, halt_wb;
  regbits_t rs_id, rt_id, rt_ex;

  always #5 CLK = ~CLK;

  pipeline_sequencer_if #(.CNT_W(16)) bus16 ();
  pipeline_sequencer_if #(.CNT_W(2))  bus2 ();

  assign bus16.ihit = ihit;     assign bus2.ihit = ihit;
  assign bus16.dhit = dhit;     assign bus2.dhit = dhit;
  assign bus16.rs_id = rs_id;   assign bus2.rs_id = rs_id;
  assign bus16.rt_id = rt_id;   assign bus2.rt_id = rt_id;
  assign bus16.dREN_ex = dREN_ex;   assign bus2.dREN_ex = dREN_ex;
  assign bus16.rt_ex = rt_ex;       assign bus2.rt_ex = rt_ex;
  assign bus16.dREN_mem = dREN_mem; assign bus2.dREN_mem = dREN_mem;
  assign bus16.dWEN_mem = dWEN_mem; assign bus2.dWEN_mem = dWEN_mem;
  assign bus16.take_mem = take_mem; assign bus2.take_mem = take_mem;
  assign bus16.halt_wb = halt_wb;   assign bus2.halt_wb = halt_wb;

  pipeline_sequencer #(.CNT_W(16)) dut16 (.CLK(CLK), .nRST(nRST), .bus(bus16));
  pipeline_sequencer #(.CNT_W(2))  dut2  (.CLK(CLK), .nRST(nRST), .bus(bus2));

  // {pc_en, en_1, en_2, en_3, en_4, flush_1, flush_2, flush_3, halted}
  wire [8:0] got16 = {bus16.pc_en, bus16.en_1, bus16.en_2, bus16.en_3, bus16.en_4,
                      bus16.flush_1, bus16.flush_2, bus16.flush_3, bus16.halted};
  wire [8:0] got2  = {bus2.pc_en, bus2.en_1, bus2.en_2, bus2.en_3, bus2.en_4,
                      bus2.flush_1, bus2.flush_2, bus2.flush_3, bus2.halted};

  int nvec = 0;
  int nmis = 0;

  // reference model: whether the core has halted, whether it waits on data memory, stall tallies
  bit m_halted, m_wait;
  int m_cnt16, m_cnt2;

  typedef struct {
    string      name;
    logic       ihit, dhit;
    logic [4:0] rs, rt;
    logic       dren_ex;
    logic [4:0] rt_ex;
    logic       dren_mem, dwen_mem, take, halt;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] model_out();
    bit dependent;
    bit access_missing;
    if (!nRST) return 9'b0_0000_111_0;
    if (m_halted) return 9'b0_0000_000_1;
    if (!m_wait && halt_wb) return 9'b0_0001_000_0;
    access_missing = m_wait ? !dhit : ((dREN_mem || dWEN_mem) && !dhit);
    if (access_missing) return 9'b0_0000_000_0;
    dependent = dREN_ex && (rt_ex != 0) && (rt_ex == rs_id || rt_ex == rt_id);
    if (take_mem) return 9'b1_1111_111_0;
    if (dependent) return 9'b0_0111_010_0;
    if (!ihit) return 9'b0_1111_100_0;
    return 9'b1_1111_000_0;
  endfunction

  // inputs already driven just after a falling edge; check, then step the model over the rising edge
  task automatic do_cycle();
    logic [8:0] e;
    #2;
    if (!nRST) begin
      m_halted = 0; m_wait = 0; m_cnt16 = 0; m_cnt2 = 0;
    end
    e = model_out();
    check("ctrl16", {23'd0, got16}, {23'd0, e});
    check("ctrl2", {23'd0, got2}, {23'd0, e});
    check("cnt16", {16'd0, bus16.stall_cnt}, m_cnt16);
    check("cnt2", {30'd0, bus2.stall_cnt}, m_cnt2);
    @(posedge CLK);
    if (nRST) begin
      if (!m_halted && !e[8]) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (!m_halted) begin
        if (m_wait) begin
          if (dhit) m_wait = 0;
        end else if (halt_wb) begin
          m_halted = 1;
        end else if ((dREN_mem || dWEN_mem) && !dhit) begin
          m_wait = 1;
        end
      end
    end
    @(negedge CLK);
  endtask

  task automatic set_idle();
    ihit = 1; dhit = 0; rs_id = 0; rt_id = 0; dREN_ex = 0; rt_ex = 0;
    dREN_mem = 0; dWEN_mem = 0; take_mem = 0; halt_wb = 0;
  endtask

  task automatic apply_reset();
    nRST = 0;
    do_cycle();
    nRST = 1;
  endtask

  initial begin
    int base;
    int hold;
    nRST = 0;
    set_idle();
    m_halted = 0; m_wait = 0; m_cnt16 = 0; m_cnt2 = 0;
    apply_reset();

    tbl[0]  = '{"run",        1'b1, 1'b0, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b1_1111_000_0};
    tbl[1]  = '{"imiss",      1'b0, 1'b0, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b0_1111_100_0};
    tbl[2]  = '{"lu_rs",      1'b1, 1'b0, 5'd2, 5'd7, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 9'b0_0111_010_0};
    tbl[3]  = '{"lu_rt",      1'b1, 1'b0, 5'd6, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 9'b0_0111_010_0};
    tbl[4]  = '{"lu_r0",      1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b1_1111_000_0};
    tbl[5]  = '{"ld_nodep",   1'b1, 1'b0, 5'd1, 5'd3, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 9'b1_1111_000_0};
    tbl[6]  = '{"br_lu",      1'b1, 1'b0, 5'd2, 5'd0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 9'b1_1111_111_0};
    tbl[7]  = '{"br_imiss",   1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 9'b1_1111_111_0};
    tbl[8]  = '{"dmiss_ld",   1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 9'b0_0000_000_0};
    tbl[9]  = '{"dmiss_st",   1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 9'b0_0000_000_0};
    tbl[10] = '{"dhit_st",    1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 9'b1_1111_000_0};
    tbl[11] = '{"halt",       1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 9'b0_0001_000_0};
    tbl[12] = '{"halt_dmiss", 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 9'b0_0001_000_0};
    tbl[13] = '{"lu_imiss",   1'b0, 1'b0, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 9'b0_0111_010_0};
    tbl[14] = '{"dmiss_br",   1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 9'b0_0000_000_0};
    tbl[15] = '{"stray_dhit", 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b1_1111_000_0};

    foreach (tbl[i]) begin
      set_idle();
      apply_reset();
      ihit = tbl[i].ihit; dhit = tbl[i].dhit; rs_id = tbl[i].rs; rt_id = tbl[i].rt;
      dREN_ex = tbl[i].dren_ex; rt_ex = tbl[i].rt_ex; dREN_mem = tbl[i].dren_mem;
      dWEN_mem = tbl[i].dwen_mem; take_mem = tbl[i].take; halt_wb = tbl[i].halt;
      #2;
      check(tbl[i].name, {23'd0, got16}, {23'd0, tbl[i].exp});
      @(negedge CLK);
    end
    set_idle();
    apply_reset();

    // load-use: one stall, then ID/EX holds the bubble and everything advances
    dREN_ex = 1; rt_ex = 2; rs_id = 2;
    do_cycle();
    dREN_ex = 0;
    #2 check("lu_release", {23'd0, got16}, {23'd0, 9'b1_1111_000_0});
    do_cycle();

    // redirect overriding load-use must not count a stall
    base = m_cnt16;
    dREN_ex = 1; rt_ex = 4; rt_id = 4; take_mem = 1;
    do_cycle();
    check("br_no_stall", {16'd0, bus16.stall_cnt}, base);
    set_idle();

    // three-cycle data miss then completion
    base = m_cnt16;
    dREN_mem = 1;
    repeat (3) do_cycle();
    dhit = 1;
    #2 check("dmiss_done", {23'd0, got16}, {23'd0, 9'b1_1111_000_0});
    do_cycle();
    check("dmiss_cnt", {16'd0, bus16.stall_cnt}, base + 3);
    set_idle();

    // halt drain: WB commits once, then everything stays frozen until reset
    halt_wb = 1;
    #2 check("halt_en4", {31'd0, bus16.en_4}, 32'd1);
    do_cycle();
    halt_wb = 0; take_mem = 1; ihit = 0;
    repeat (3) do_cycle();
    check("halted_sticky", {23'd0, got16}, {23'd0, 9'b0_0000_000_1});
    set_idle();
    apply_reset();
    check("halt_cleared", {31'd0, bus16.halted}, 32'd0);

    // narrow counter saturates
    ihit = 0;
    repeat (5) do_cycle();
    check("cnt2_sat", {30'd0, bus2.stall_cnt}, 32'd3);
    set_idle();

    // reset during a data wait drops the pending access
    dWEN_mem = 1;
    repeat (2) do_cycle();
    apply_reset();
    dWEN_mem = 0;
    #2 check("rst_dwait", {23'd0, got16}, {23'd0, 9'b1_1111_000_0});
    do_cycle();

    // randomized traffic against the model
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      ihit     = ($urandom % 4) != 0;
      dhit     = ($urandom % 3) != 0;
      rs_id    = 5'($urandom % 4);
      rt_id    = 5'($urandom % 4);
      rt_ex    = 5'($urandom % 4);
      dREN_ex  = ($urandom % 2) != 0;
      dREN_mem = ($urandom % 4) == 0;
      dWEN_mem = ($urandom % 5) == 0;
      take_mem = ($urandom % 8) == 0;
      halt_wb  = ($urandom % 80) == 0;
      hold = m_halted ? hold + 1 : 0;
      if (hold > 6 || ($urandom % 150) == 0) begin
        apply_reset();
        hold = 0;
      end else begin
        do_cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
